operand_buffer: RTL

- Operand storage stage directly upstream of the systolic array.
- Captures the 8-byte host stream (four weights and four inputs of a 2x2 by 2x2 matmul) at the address driven by the control unit.
- Steers the operand bytes onto the four array edge inputs a0/a1/b0/b1 using the control unit's per-cycle select codes and its transpose flag.
- Registers the steered operands so the array sees stable, zero-gated data.

---
 rtl/operand_buffer_if.sv | 34 +++
 rtl/operand_buffer.sv | 117 +++++++++++
 2 files changed

// File: rtl/operand_buffer_if.sv
// Host-write, operand-select and array-edge signals of the operand buffer.
interface operand_buffer_if #(
    parameter int unsigned DATA_W = 8
);
    logic              load_en;
    logic [2:0]        mem_addr;
    logic [DATA_W-1:0] host_indata;
    logic              data_valid;
    logic [1:0]        a0_sel;
    logic [1:0]        a1_sel;
    logic [1:0]        b0_sel;
    logic [1:0]        b1_sel;
    logic              transpose;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] b1;
    logic              frame_done;
    logic              bank_sel;

    // Control unit / host side
    modport master (
        output load_en, mem_addr, host_indata, data_valid,
        output a0_sel, a1_sel, b0_sel, b1_sel, transpose,
        input  a0, a1, b0, b1, frame_done, bank_sel
    );

    // Operand buffer side
    modport slave (
        input  load_en, mem_addr, host_indata, data_valid,
        input  a0_sel, a1_sel, b0_sel, b1_sel, transpose,
        output a0, a1, b0, b1, frame_done, bank_sel
    );
endinterface

// File: rtl/operand_buffer.sv
// Operand storage ahead of the 2x2 systolic array: captures W0..W3/X0..X3,
// steers them onto the a0/a1/b0/b1 edges and registers them zero-gated.
// Optional macro OPERAND_PINGPONG_EN: two banks, read bank swaps on the
// address-7 write; otherwise one bank with write-through forwarding.
module operand_buffer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    operand_buffer_if.slave  bus
);
`ifdef OPERAND_PINGPONG_EN
    localparam int unsigned NBANK = 2;
`else
    localparam int unsigned NBANK = 1;
`endif
    localparam int unsigned FRAME = 8;
    localparam int unsigned DEPTH = NBANK * FRAME;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned EDGES = 4;

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [DATA_W-1:0] mem_d  [DEPTH];
    logic [DATA_W-1:0] edge_q [EDGES];
    logic [DATA_W-1:0] edge_d [EDGES];
    logic              frame_done_q, frame_done_d;
    logic              bank_sel_q, bank_sel_d;
`ifdef OPERAND_PINGPONG_EN
    logic              wbank_q, wbank_d;
`endif

    logic [2:0]        sel_addr [EDGES];
    logic              sel_en   [EDGES];
    logic [DATA_W-1:0] sel_byte [EDGES];
    logic [IDX_W-1:0]  rd_idx   [EDGES];
    logic [IDX_W-1:0]  wr_idx;
    logic              frame_end;

    // Decode each edge's select code (and transpose) into a frame address
    always_comb begin
        sel_en[0]   = ~bus.a0_sel[1];
        sel_addr[0] = bus.a0_sel[0] ? 3'd1 : 3'd0;
        sel_en[1]   = ~bus.a1_sel[1];
        sel_addr[1] = bus.a1_sel[0] ? 3'd3 : 3'd2;
        sel_en[2]   = ~bus.b0_sel[1];
        sel_addr[2] = ~bus.b0_sel[0] ? 3'd4 : (bus.transpose ? 3'd6 : 3'd5);
        sel_en[3]   = ~bus.b1_sel[1];
        sel_addr[3] = bus.b1_sel[0] ? 3'd7 : (bus.transpose ? 3'd5 : 3'd6);
    end

    // Read the selected bytes, forwarding a same-cycle write in single-bank mode
    always_comb begin
        for (int i = 0; i < int'(EDGES); i++) begin
`ifdef OPERAND_PINGPONG_EN
            rd_idx[i]   = {bank_sel_q, sel_addr[i]};
            sel_byte[i] = mem_q[rd_idx[i]];
`else
            rd_idx[i]   = sel_addr[i];
            sel_byte[i] = mem_q[rd_idx[i]];
            if (bus.load_en && (bus.mem_addr == sel_addr[i])) begin
                sel_byte[i] = bus.host_indata;
            end
`endif
            edge_d[i] = (bus.data_valid && sel_en[i]) ? sel_byte[i] : '0;
        end
    end

    // Storage write, frame-end pulse and bank swap
    always_comb begin
        mem_d        = mem_q;
        frame_end    = bus.load_en && (bus.mem_addr == 3'd7);
        frame_done_d = frame_end;
`ifdef OPERAND_PINGPONG_EN
        wr_idx     = {wbank_q, bus.mem_addr};
        bank_sel_d = bank_sel_q;
        wbank_d    = wbank_q;
        if (frame_end) begin
            bank_sel_d = wbank_q;
            wbank_d    = ~wbank_q;
        end
`else
        wr_idx     = bus.mem_addr;
        bank_sel_d = 1'b0;
`endif
        if (bus.load_en) begin
            mem_d[wr_idx] = bus.host_indata;
        end
    end

    // State registers, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            for (int i = 0; i < int'(EDGES); i++) edge_q[i] <= '0;
            frame_done_q <= 1'b0;
            bank_sel_q   <= 1'b0;
`ifdef OPERAND_PINGPONG_EN
            wbank_q      <= 1'b0;
`endif
        end else begin
            mem_q        <= mem_d;
            edge_q       <= edge_d;
            frame_done_q <= frame_done_d;
            bank_sel_q   <= bank_sel_d;
`ifdef OPERAND_PINGPONG_EN
            wbank_q      <= wbank_d;
`endif
        end
    end

    assign bus.a0         = edge_q[0];
    assign bus.a1         = edge_q[1];
    assign bus.b0         = edge_q[2];
    assign bus.b1         = edge_q[3];
    assign bus.frame_done = frame_done_q;
    assign bus.bank_sel   = bank_sel_q;
endmodule
